// File: rtl/sk9822_strip_driver.sv
// SK9822 / APA102-style LED strip driver.
// Shifts a start frame (32 zeros), one 32-bit word per LED (top three bits
// forced high), and an end frame of 32*ceil(n_leds/64) ones, MSB first.
// Optional feature macro: SK9822_STRIP_AUTO_REFRESH_EN -- when defined, the
// driver re-sends the strip contents after refresh_gap idle cycles.
module sk9822_strip_driver #(
    parameter int unsigned n_leds      = 13,
    parameter int unsigned clk_div     = 4,
    parameter int unsigned refresh_gap = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*n_leds-1:0]  data_rgb,
    output logic                  busy,
    output logic                  done,
    output logic                  sk9822_clk,
    output logic                  sk9822_data
);

    localparam int unsigned DATA_W    = 32 * n_leds;
    localparam int unsigned END_WORDS = (n_leds + 63) / 64;
    localparam int unsigned DIV_W     = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int unsigned WORD_W    = $clog2(n_leds + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(clk_div - 1);
    localparam logic [WORD_W-1:0] LED_LAST = WORD_W'(n_leds - 1);
    localparam logic [WORD_W-1:0] END_LAST = WORD_W'(END_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_FRM = 2'd1,
        LED_FRM   = 2'd2,
        END_FRM   = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shadow;
    logic [31:0]         shift_word;
    logic [DIV_W-1:0]    div_cnt;
    logic [4:0]          bit_cnt;
    logic [WORD_W-1:0]   word_cnt;
    logic                fire_c;
    logic [31:0]         next_led_c;

    // Next LED word comes from the top of the shadow, brightness header forced to 3'b111
    assign next_led_c = {3'b111, shadow[DATA_W-4 -: 29]};

`ifdef SK9822_STRIP_AUTO_REFRESH_EN
    localparam int unsigned GAP_W = $clog2(refresh_gap + 1);

    logic [GAP_W-1:0] gap_cnt;

    assign fire_c = start || (gap_cnt == GAP_W'(refresh_gap - 1));

    // Idle timer: counts only in IDLE, restarts on every accepted frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if ((state != IDLE) || fire_c) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    assign fire_c = start;
`endif

    // Frame sequencer: bit timing, word loading and registered serial outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            sk9822_clk  <= 1'b0;
            sk9822_data <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            shift_word  <= '0;
            shadow      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (fire_c) begin
                    shadow      <= data_rgb;
                    state       <= START_FRM;
                    busy        <= 1'b1;
                    sk9822_clk  <= 1'b0;
                    sk9822_data <= 1'b0;
                    shift_word  <= '0;
                    div_cnt     <= '0;
                    bit_cnt     <= '0;
                    word_cnt    <= '0;
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
            end else if (!sk9822_clk) begin
                // Low half done: raise sck, data already stable
                div_cnt    <= '0;
                sk9822_clk <= 1'b1;
            end else begin
                // High half done: end of a bit period
                div_cnt    <= '0;
                sk9822_clk <= 1'b0;
                if (bit_cnt != 5'd31) begin
                    bit_cnt     <= bit_cnt + 1'b1;
                    shift_word  <= shift_word << 1;
                    sk9822_data <= shift_word[30];
                end else begin
                    bit_cnt <= '0;
                    if ((state == START_FRM) ||
                        ((state == LED_FRM) && (word_cnt != LED_LAST))) begin
                        shift_word  <= next_led_c;
                        sk9822_data <= next_led_c[31];
                        shadow      <= shadow << 32;
                        word_cnt    <= (state == START_FRM) ? '0 : word_cnt + 1'b1;
                        state       <= LED_FRM;
                    end else if (state == LED_FRM) begin
                        shift_word  <= '1;
                        sk9822_data <= 1'b1;
                        word_cnt    <= '0;
                        state       <= END_FRM;
                    end else if (word_cnt != END_LAST) begin
                        shift_word  <= '1;
                        sk9822_data <= 1'b1;
                        word_cnt    <= word_cnt + 1'b1;
                    end else begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        sk9822_data <= 1'b0;
                        word_cnt    <= '0;
                    end
                end
            end
        end
    end

endmodule
